// File: rtl/fir_pkg.sv
// Shared types and elaboration helpers for the parametrised sequential FIR core.
// The ACC_W macros let any instantiating module reject an accumulator that could overflow.
`ifndef FIR_PKG_MACROS
`define FIR_PKG_MACROS
`define FIR_ACC_W_MIN(data_w, coef_w, ntaps) ((data_w) + (coef_w) + fir_pkg::fir_clog2(ntaps))
`define FIR_ACC_W_OK(acc_w, data_w, coef_w, ntaps) ((acc_w) >= `FIR_ACC_W_MIN(data_w, coef_w, ntaps))
`endif

package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_t;

    // Ceiling log2, usable in constant expressions such as port widths.
    function automatic int fir_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output scaling: optional round-half-up arithmetic shift, then
// saturation of the accumulator to the signed DATA_W output range.
module fir_round_sat #(
    parameter int ACC_W     = 40,
    parameter int DATA_W    = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] data,
    output logic                     sat
);

    // One guard bit so the rounding add can never wrap.
    localparam int EW = ACC_W + 1;
    localparam logic signed [EW-1:0] MAX_V = {{(EW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] r;

    assign ext = {acc[ACC_W-1], acc};

    generate
        if (OUT_SHIFT > 0) begin : g_round
            localparam logic signed [EW-1:0] HALF = EW'(1) << (OUT_SHIFT - 1);
            assign r = (ext + HALF) >>> OUT_SHIFT;
        end else begin : g_pass
            assign r = ext;
        end
    endgenerate

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data = r[DATA_W-1:0];
        sat  = 1'b0;
        if (r > MAX_V) begin
            data = MAX_V[DATA_W-1:0];
            sat  = 1'b1;
        end else if (r < MIN_V) begin
            data = MIN_V[DATA_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_seq_param.sv
// Resource-shared FIR core: one multiplier walks NTAPS taps per sample under an
// IDLE/MAC/OUT FSM, with valid/ready streaming and run-time coefficient writes.
module fir_seq_param
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NTAPS     = 16,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      out_data,
    output logic                          out_sat,
    input  logic                          coef_we,
    input  logic [fir_clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    output logic                          coef_ack,
    output logic                          busy
);

    localparam int AW = fir_clog2(NTAPS);
    localparam int PW = DATA_W + COEF_W;

    generate
        if (!`FIR_ACC_W_OK(ACC_W, DATA_W, COEF_W, NTAPS)) begin : g_bad_acc_w
            $error("fir_seq_param: ACC_W narrower than DATA_W+COEF_W+clog2(NTAPS)");
        end
        if (NTAPS < 2 || NTAPS > 64) begin : g_bad_ntaps
            $error("fir_seq_param: NTAPS must be in 2..64");
        end
        if (OUT_SHIFT < 0 || OUT_SHIFT > ACC_W - DATA_W) begin : g_bad_shift
            $error("fir_seq_param: OUT_SHIFT must be in 0..ACC_W-DATA_W");
        end
    endgenerate

    fir_state_t               state;
    logic signed [DATA_W-1:0] x    [NTAPS];
    logic signed [COEF_W-1:0] coef [NTAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [PW-1:0]     prod;
    logic [AW-1:0]            tap;
    logic signed [DATA_W-1:0] scaled;
    logic                     scaled_sat;
    logic                     in_fire;
    logic                     coef_fire;
    logic                     last_tap;

    assign in_fire   = in_valid && in_ready;
    // Input wins over a same-cycle coefficient write so taps never change mid-sample.
    assign coef_fire = coef_we && (state == IDLE) && !in_fire;
    assign last_tap  = (tap == AW'(NTAPS - 1));
    assign prod      = PW'(x[tap]) * PW'(coef[tap]);
    assign acc_next  = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

    // Scale the final sum combinationally so the result registers on OUT entry.
    fir_round_sat #(
        .ACC_W    (ACC_W),
        .DATA_W   (DATA_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_round_sat (
        .acc (acc_next),
        .data(scaled),
        .sat (scaled_sat)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            tap       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            coef_ack  <= 1'b0;
            busy      <= 1'b0;
            // NOTE: history and taps are reset explicitly; reset must yield a clean filter.
            for (int k = 0; k < NTAPS; k++) begin
                x[k]    <= '0;
                coef[k] <= '0;
            end
        end else begin
            coef_ack <= coef_fire;
            if (coef_fire) begin
                coef[coef_addr] <= coef_data;
            end

            case (state)
                IDLE: begin
                    if (in_fire) begin
                        x[0] <= in_data;
                        for (int k = 1; k < NTAPS; k++) begin
                            x[k] <= x[k-1];
                        end
                        acc      <= '0;
                        tap      <= '0;
                        state    <= MAC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    tap <= tap + AW'(1);
                    if (last_tap) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_data  <= scaled;
                        out_sat   <= scaled_sat;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_param.sv
// Bench for fir_seq_param: two instances (OUT_SHIFT 0 and 4) share stimulus and are
// compared against a sum-of-products reference model of the filter.
module tb_fir_seq_param;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int NTAPS  = 16;
    localparam int ACC_W  = 40;
    localparam int AW     = 4;
    localparam int SH1    = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_ready;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;

    logic                     in_ready0, out_valid0, out_sat0, coef_ack0, busy0;
    logic signed [DATA_W-1:0] out_data0;
    logic                     in_ready1, out_valid1, out_sat1, coef_ack1, busy1;
    logic signed [DATA_W-1:0] out_data1;

    int checks   = 0;
    int failures = 0;

    longint hist [NTAPS];
    longint cf   [NTAPS];

    always #5 clk = ~clk;

    fir_seq_param #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .ACC_W(ACC_W), .OUT_SHIFT(0)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ack(coef_ack0),
        .busy(busy0)
    );

    fir_seq_param #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .ACC_W(ACC_W), .OUT_SHIFT(SH1)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ack(coef_ack1),
        .busy(busy1)
    );

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            hist[k] = 0;
            cf[k]   = 0;
        end
    endfunction

    function automatic void model_push(input longint s);
        for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
    endfunction

    function automatic void model_out(input int sh, output logic signed [DATA_W-1:0] d,
                                      output logic s);
        longint a;
        longint r;
        a = 0;
        for (int k = 0; k < NTAPS; k++) a += hist[k] * cf[k];
        r = (sh > 0) ? ((a + (longint'(1) << (sh - 1))) >>> sh) : a;
        s = 1'b1;
        if (r > 32767)       d = 16'sh7fff;
        else if (r < -32768) d = 16'sh8000;
        else begin
            d = DATA_W'(r);
            s = 1'b0;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input logic signed [COEF_W-1:0] data,
                              output logic ack0, output logic ack1);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = data;
        tick();
        coef_we = 1'b0;
        ack0    = coef_ack0;
        ack1    = coef_ack1;
        cf[addr] = longint'(data);
    endtask

    task automatic load_coefs_const(input logic signed [COEF_W-1:0] v, input bit ramp);
        logic a0, a1;
        for (int k = 0; k < NTAPS; k++)
            write_coef(k, ramp ? COEF_W'(k + 1) : v, a0, a1);
    endtask

    task automatic accept_sample(input logic signed [DATA_W-1:0] d, output bit ok);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!(in_ready0 && in_ready1) && n < 200) begin
            tick();
            n++;
        end
        ok = (n < 200);
        tick();
        in_valid = 1'b0;
        model_push(longint'(d));
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid0 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_sample(input logic signed [DATA_W-1:0] d, output int lat,
                             output logic signed [DATA_W-1:0] g0, output logic gs0,
                             output logic signed [DATA_W-1:0] g1, output logic gs1);
        bit ok;
        accept_sample(d, ok);
        wait_result(lat);
        if (!ok) lat = -1;
        g0 = out_data0; gs0 = out_sat0;
        g1 = out_data1; gs1 = out_sat1;
        pop_result();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({in_ready0, out_valid0, out_sat0, coef_ack0, busy0} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags0: got %b want 10000",
                     {in_ready0, out_valid0, out_sat0, coef_ack0, busy0});
        end
        checks++;
        if ({in_ready1, out_valid1, out_sat1, coef_ack1, busy1} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags1: got %b want 10000",
                     {in_ready1, out_valid1, out_sat1, coef_ack1, busy1});
        end
        checks++;
        if (out_data0 !== 16'sd0 || out_data1 !== 16'sd0) begin
            failures++;
            $display("FAIL reset_data: got %0d/%0d want 0/0", out_data0, out_data1);
        end
    endtask

    task automatic test_impulse();
        int lat;
        logic signed [DATA_W-1:0] g0, g1, e1;
        logic gs0, gs1, es1;
        load_coefs_const('0, 1'b1);
        for (int i = 0; i < NTAPS + 2; i++) begin
            do_sample((i == 0) ? 16'sd1 : 16'sd0, lat, g0, gs0, g1, gs1);
            model_out(SH1, e1, es1);
            checks++;
            if (lat != NTAPS) begin
                failures++;
                $display("FAIL impulse_latency[%0d]: got %0d want %0d", i, lat, NTAPS);
            end
            checks++;
            if (g0 !== DATA_W'((i < NTAPS) ? i + 1 : 0) || gs0 !== 1'b0) begin
                failures++;
                $display("FAIL impulse_out[%0d]: got %0d sat %b want %0d sat 0",
                         i, g0, gs0, (i < NTAPS) ? i + 1 : 0);
            end
            checks++;
            if (g1 !== e1 || gs1 !== es1) begin
                failures++;
                $display("FAIL impulse_shift4[%0d]: got %0d sat %b want %0d sat %b",
                         i, g1, gs1, e1, es1);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic signed [DATA_W-1:0] g0, g1, e1;
        logic gs0, gs1, es1;
        load_coefs_const(16'sh7fff, 1'b0);
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < NTAPS; i++)
                do_sample(phase == 0 ? 16'sh7fff : 16'sh8000, lat, g0, gs0, g1, gs1);
            model_out(SH1, e1, es1);
            checks++;
            if (g0 !== (phase == 0 ? 16'sh7fff : 16'sh8000) || gs0 !== 1'b1) begin
                failures++;
                $display("FAIL sat_phase%0d: got %0d sat %b want %0d sat 1",
                         phase, g0, gs0, phase == 0 ? 32767 : -32768);
            end
            checks++;
            if (g1 !== e1 || gs1 !== es1) begin
                failures++;
                $display("FAIL sat_shift4_phase%0d: got %0d sat %b want %0d sat %b",
                         phase, g1, gs1, e1, es1);
            end
        end
    endtask

    task automatic test_rounding();
        int lat;
        logic signed [DATA_W-1:0] g0, g1;
        logic gs0, gs1, a0, a1;
        logic signed [DATA_W-1:0] ins  [4] = '{16'sd24, -16'sd24, 16'sd8, 16'sd7};
        logic signed [DATA_W-1:0] exps [4] = '{16'sd2,  -16'sd1,  16'sd1, 16'sd0};
        for (int k = 0; k < NTAPS; k++) write_coef(k, (k == 0) ? 16'sd1 : 16'sd0, a0, a1);
        for (int i = 0; i < 4; i++) begin
            do_sample(ins[i], lat, g0, gs0, g1, gs1);
            checks++;
            if (g1 !== exps[i] || gs1 !== 1'b0) begin
                failures++;
                $display("FAIL round[%0d]: got %0d sat %b want %0d sat 0", i, g1, gs1, exps[i]);
            end
            checks++;
            if (g0 !== ins[i] || gs0 !== 1'b0) begin
                failures++;
                $display("FAIL round_noshift[%0d]: got %0d want %0d", i, g0, ins[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic signed [DATA_W-1:0] g0, g1, e0, e1;
        logic gs0, gs1, es0, es1, a0, a1;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < NTAPS; k++)
                write_coef(k, round == 0 ? COEF_W'($urandom_range(511) - 256) : COEF_W'($urandom),
                           a0, a1);
            for (int i = 0; i < 10; i++) begin
                do_sample(DATA_W'($urandom), lat, g0, gs0, g1, gs1);
                model_out(0, e0, es0);
                model_out(SH1, e1, es1);
                checks++;
                if (g0 !== e0 || gs0 !== es0 || g1 !== e1 || gs1 !== es1 || lat != NTAPS) begin
                    failures++;
                    $display("FAIL random[%0d.%0d]: got %0d/%b %0d/%b lat %0d want %0d/%b %0d/%b lat %0d",
                             round, i, g0, gs0, g1, gs1, lat, e0, es0, e1, es1, NTAPS);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        logic signed [DATA_W-1:0] e0, b;
        logic es0;
        out_ready = 1'b0;
        accept_sample(DATA_W'($urandom), ok);
        wait_result(lat);
        model_out(0, e0, es0);
        b = DATA_W'($urandom);
        in_data  = b;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            checks++;
            if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || out_data0 !== e0 || out_sat0 !== es0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: in_ready %b out_valid %b data %0d want 0 1 %0d",
                         c, in_ready0, out_valid0, out_data0, e0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: out_valid %b in_ready %b want 0 1", out_valid0, in_ready0);
        end
        tick();
        in_valid = 1'b0;
        model_push(longint'(b));
        checks++;
        if (busy0 !== 1'b1 || in_ready0 !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_accept: busy %b in_ready %b want 1 0", busy0, in_ready0);
        end
        wait_result(lat);
        model_out(0, e0, es0);
        checks++;
        if (lat != NTAPS || out_data0 !== e0 || out_sat0 !== es0) begin
            failures++;
            $display("FAIL bp_next_result: got %0d lat %0d want %0d lat %0d", out_data0, lat, e0, NTAPS);
        end
        pop_result();
    endtask

    task automatic test_back_to_back();
        logic signed [DATA_W-1:0] expq [$];
        logic signed [DATA_W-1:0] e0;
        logic es0, will_acc, will_hs;
        int last_acc, cyc, naccepted;
        last_acc  = -1;
        naccepted = 0;
        in_data   = DATA_W'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 6 * (NTAPS + 2); cyc++) begin
            if (naccepted == 4) in_valid = 1'b0;
            will_acc = in_valid && in_ready0;
            will_hs  = out_valid0 && out_ready;
            if (will_hs) begin
                checks++;
                if (expq.size() == 0 || out_data0 !== expq[0]) begin
                    failures++;
                    $display("FAIL b2b_data: got %0d want %0d", out_data0,
                             expq.size() ? expq[0] : 16'sd0);
                end
                if (expq.size() != 0) void'(expq.pop_front());
            end
            tick();
            if (will_acc) begin
                model_push(longint'(in_data));
                model_out(0, e0, es0);
                expq.push_back(e0);
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != NTAPS + 2) begin
                        failures++;
                        $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_acc, NTAPS + 2);
                    end
                end
                last_acc = cyc;
                naccepted++;
                in_data = DATA_W'($urandom);
            end
        end
        out_ready = 1'b0;
        checks++;
        if (expq.size() != 0 || naccepted != 4 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: pending %0d accepted %0d busy %b want 0 4 0",
                     expq.size(), naccepted, busy0);
        end
    endtask

    task automatic test_coef_gating();
        int lat;
        bit ok;
        logic signed [DATA_W-1:0] g0, g1, e0;
        logic gs0, gs1, es0, a0, a1;
        // write attempted during MAC and OUT
        accept_sample(DATA_W'($urandom), ok);
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd12345;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (coef_ack0 !== 1'b0 || coef_ack1 !== 1'b0) begin
                failures++;
                $display("FAIL gate_mac_ack[%0d]: got %b%b want 00", c, coef_ack0, coef_ack1);
            end
        end
        coef_we = 1'b0;
        wait_result(lat);
        coef_we = 1'b1;
        tick();
        coef_we = 1'b0;
        checks++;
        if (coef_ack0 !== 1'b0 || coef_ack1 !== 1'b0) begin
            failures++;
            $display("FAIL gate_out_ack: got %b%b want 00", coef_ack0, coef_ack1);
        end
        model_out(0, e0, es0);
        checks++;
        if (out_data0 !== e0 || out_sat0 !== es0) begin
            failures++;
            $display("FAIL gate_mac_result: got %0d want %0d", out_data0, e0);
        end
        pop_result();
        // write colliding with an input handshake
        in_data = DATA_W'($urandom); in_valid = 1'b1;
        coef_we = 1'b1; coef_addr = '0; coef_data = -16'sd777;
        tick();
        in_valid = 1'b0; coef_we = 1'b0;
        model_push(longint'(in_data));
        checks++;
        if (busy0 !== 1'b1 || coef_ack0 !== 1'b0) begin
            failures++;
            $display("FAIL gate_collide: busy %b ack %b want 1 0", busy0, coef_ack0);
        end
        wait_result(lat);
        model_out(0, e0, es0);
        checks++;
        if (out_data0 !== e0 || out_sat0 !== es0) begin
            failures++;
            $display("FAIL gate_collide_result: got %0d want %0d", out_data0, e0);
        end
        pop_result();
        // write alone in IDLE
        write_coef(0, 16'sd321, a0, a1);
        checks++;
        if (a0 !== 1'b1 || a1 !== 1'b1) begin
            failures++;
            $display("FAIL gate_idle_ack: got %b%b want 11", a0, a1);
        end
        tick();
        checks++;
        if (coef_ack0 !== 1'b0) begin
            failures++;
            $display("FAIL gate_ack_pulse: got %b want 0", coef_ack0);
        end
        do_sample(DATA_W'($urandom), lat, g0, gs0, g1, gs1);
        model_out(0, e0, es0);
        checks++;
        if (g0 !== e0 || gs0 !== es0) begin
            failures++;
            $display("FAIL gate_idle_result: got %0d want %0d", g0, e0);
        end
    endtask

    task automatic test_reset_mid_mac();
        bit ok;
        accept_sample(DATA_W'($urandom), ok);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        checks++;
        if ({busy0, in_ready0, out_valid0, out_sat0, coef_ack0} !== 5'b01000 ||
            {busy1, in_ready1, out_valid1} !== 3'b010) begin
            failures++;
            $display("FAIL midmac_reset_flags: got %b %b want 01000 010",
                     {busy0, in_ready0, out_valid0, out_sat0, coef_ack0},
                     {busy1, in_ready1, out_valid1});
        end
        checks++;
        if (out_data0 !== 16'sd0) begin
            failures++;
            $display("FAIL midmac_reset_data: got %0d want 0", out_data0);
        end
        test_impulse();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_saturation();
        test_rounding();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_coef_gating();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_seq_param.md
Name: fir_seq_param

Overview:
Parametrised, resource-shared FIR filter core and successor to the fixed 16-tap/32-bit sequential FIR core. One multiplier is time-multiplexed across NTAPS taps under a small FSM. It adds valid/ready streaming on input and output, run-time loadable coefficients, and rounding/saturating output scaling. It sits between the sample source and the downstream consumer in the DSP datapath.

Parameters:
DATA_W, 16, signed sample width (in and out)
COEF_W, 16, signed coefficient width
NTAPS, 16, number of taps (2..64)
ACC_W, 40, signed accumulator width; elaboration error if < DATA_W+COEF_W+clog2(NTAPS)
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..ACC_W-DATA_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input sample valid
in_ready  out  1  core can accept a sample
in_data  in  DATA_W  signed input sample
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  signed filtered sample
out_sat  out  1  out_data was saturated; qualified by out_valid
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NTAPS)  tap index; 0 = newest sample
coef_data  in  COEF_W  signed coefficient
coef_ack  out  1  one-cycle pulse: write accepted
busy  out  1  FSM not in IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: FSM=IDLE; delay line x[0..NTAPS-1]=0; coef[0..NTAPS-1]=0; acc=0; in_ready=1, out_valid=0, out_data=0, out_sat=0, coef_ack=0, busy=0. A reset mid-operation discards the in-flight sample and its result.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: shift the delay line (x[k]<=x[k-1], x[0]<=in_data), clear acc, tap counter i=0, go to MAC.
- MAC:
  - in_ready=0.
  - Each cycle: acc <= acc + sext(x[i]*coef[i]). The product is a full DATA_W+COEF_W signed value. The accumulator wraps at ACC_W and cannot overflow by construction.
  - i increments each cycle. After the cycle with i=NTAPS-1, go to OUT.
  - MAC lasts exactly NTAPS cycles.
- OUT:
  - out_valid=1. out_data and out_sat are registered on OUT entry and held stable until the handshake.
  - On out_ready, go to IDLE.
- Output scaling:
  - If OUT_SHIFT>0: r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half up. Otherwise r = acc.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_sat=1 iff clamped.
  - The rounding add is done at ACC_W+1 bits so it cannot wrap.
- Latency: a sample accepted on edge T gives out_valid=1 from cycle T+NTAPS+1.
- Throughput: maximum one sample per NTAPS+2 cycles with out_ready held high. in_ready returns to 1 in the cycle after the output handshake.
- Backpressure: OUT is held indefinitely. in_ready stays 0, and no sample is lost or overwritten.
- Coefficient writes:
  - A write is accepted only when FSM=IDLE and no input handshake occurs in the same cycle. Input has priority.
  - An accepted write updates coef[coef_addr] at the edge and pulses coef_ack in the next cycle.
  - Writes attempted in MAC/OUT, or colliding with an input handshake, are ignored and coef_ack stays 0. This guarantees that coefficients are constant for the whole computation of a sample.
- The delay line is not cleared between samples, so filter history persists. Only rst clears it.

Decomposition:
- Shared package fir_pkg:
  - fir_state_t enum (IDLE, MAC, OUT)
  - clog2 function
  - width-check macros for the ACC_W rule
- One sub-module, fir_round_sat: combinational shift/round/saturate, parametrised by ACC_W, DATA_W, OUT_SHIFT.
- The FSM, delay line, coefficient register file and MAC stay in the top module.

Test Plan:
- Impulse: NTAPS=16, OUT_SHIFT=0, coef[k]=k+1; feed 1 then 17 zeros -> out_data = 1,2,...,16, then 0,0; out_sat=0; each output at exactly T+17 after acceptance.
- Saturation: coef all 0x7FFF, feed 0x7FFF x16 -> final out_data=0x7FFF, out_sat=1. Then reload history with 0x8000 x16 -> out_data=0x8000, out_sat=1.
- Rounding: OUT_SHIFT=4, coef[0]=1, all other coefs 0; input 24 -> 2 (24/16=1.5 rounds up); input -24 -> -1; input 8 -> 1; input 7 -> 0.
- Backpressure: hold out_ready=0 for 50 cycles with in_valid=1 -> in_ready=0 throughout, out_data stable; release -> exactly one handshake, next sample accepted in the following cycle.
- Coefficient gating:
  - coef_we during MAC -> coef_ack=0, result unchanged from golden model.
  - coef_we in IDLE with in_valid=1 -> sample taken, write ignored.
  - coef_we in IDLE alone -> coef_ack=1 next cycle.
- Reset mid-MAC: assert rst at MAC cycle 5 -> next cycle busy=0, in_ready=1, out_valid=0, all-zero history. Impulse test then repeats the identical response.
